ov_fifo_reader: RTL and testbench

//  Read side of the AL422 camera frame FIFO. Runs after the write side has stored one OV7670 frame.

---
 rtl/ov_pkg.sv | 41 ++++
 rtl/ov_pix_counter.sv | 55 +++++
 rtl/ov_fifo_reader.sv | 219 +++++++++++++++++++++
 tb/tb_ov_fifo_reader.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov_pkg.sv
// Shared types and constants for the AL422 frame FIFO reader: FSM state encoding,
// default frame geometry and the RGB565 colour-bar palette.
package ov_pkg;

   localparam int DEF_H_PIX   = 320;
   localparam int DEF_V_LINES = 240;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RRST     = 3'd1,
      ST_FETCH_HI = 3'd2,
      ST_FETCH_LO = 3'd3,
      ST_PUSH     = 3'd4,
      ST_FIN      = 3'd5
   } ov_state_e;

   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ov_pix_counter.sv
// Pixel position counters for one frame: x wraps at H_PIX-1 and bumps y; the last pixel
// of the frame returns both to zero. Provides start-of-frame/line and last-pixel flags.
module ov_pix_counter
   import ov_pkg::*;
#(
   parameter int H_PIX   = DEF_H_PIX,
   parameter int V_LINES = DEF_V_LINES,
   parameter int XW      = (H_PIX > 1) ? $clog2(H_PIX) : 1,
   parameter int YW      = (V_LINES > 1) ? $clog2(V_LINES) : 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          clear,
   input  logic          advance,
   output logic [XW-1:0] x_cnt,
   output logic [YW-1:0] y_cnt,
   output logic          sof,
   output logic          sol,
   output logic          last
);

   logic [XW-1:0] x_r;
   logic [YW-1:0] y_r;
   logic          x_end_s;
   logic          last_s;

   assign x_end_s = (x_r == XW'(H_PIX - 1));
   assign last_s  = x_end_s && (y_r == YW'(V_LINES - 1));

   // Position counters
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         x_r <= '0;
         y_r <= '0;
      end else if (clear || (advance && last_s)) begin
         x_r <= '0;
         y_r <= '0;
      end else if (advance && x_end_s) begin
         x_r <= '0;
         y_r <= y_r + YW'(1);
      end else if (advance) begin
         x_r <= x_r + XW'(1);
      end else begin
         x_r <= x_r;
         y_r <= y_r;
      end
   end

   assign x_cnt = x_r;
   assign y_cnt = y_r;
   assign sol   = (x_r == '0);
   assign sof   = (x_r == '0) && (y_r == '0);
   assign last  = last_s;

endmodule

// File: rtl/ov_fifo_reader.sv
// AL422 frame FIFO read side: pointer reset, byte-pair fetch, RGB565 pixel stream, DONE at end of frame.
// Optional colour-bar source enabled by defining OV_TEST_PATTERN_EN (adds the TP_EN input).
module ov_fifo_reader
   import ov_pkg::*;
#(
   parameter int H_PIX    = DEF_H_PIX,
   parameter int V_LINES  = DEF_V_LINES,
   parameter int RRST_CYC = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
`ifdef OV_TEST_PATTERN_EN
   input  logic        TP_EN,
`endif
   input  logic [7:0]  OV_DATA,
   output logic        OV_RCLK,
   output logic        OV_RRST,
   output logic        OV_OE,
   output logic [15:0] PIX_DATA,
   output logic        PIX_VALID,
   input  logic        PIX_READY,
   output logic        PIX_SOF,
   output logic        PIX_SOL,
   output logic        BUSY,
   output logic        DONE
);

   localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam int CW = $clog2(2 * RRST_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST_RISE = CW'(2 * RRST_CYC - 1);
   localparam logic [CW-1:0] CNT_RELEASE   = CW'(2 * RRST_CYC);

   ov_state_e     state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic          rclk_r, rclk_nxt_s;
   logic          rrst_r, rrst_nxt_s;
   logic          oe_r, oe_nxt_s;
   logic          ov_rclk_r, ov_rrst_r, ov_oe_r;
   logic [15:0]   data_r, data_nxt_s;
   logic          valid_r, valid_nxt_s;
   logic          sof_r, sof_nxt_s, sol_r, sol_nxt_s;
   logic          busy_r, busy_nxt_s, done_r, done_nxt_s;
   logic          tp_r, tp_nxt_s;
   logic          clr_s, adv_s;
   logic [XW-1:0] x_cnt_s;
   logic [YW-1:0] y_cnt_s;
   logic          sof_s, sol_s, last_s;
   logic [15:0]   src_pix_s;

   ov_pix_counter #(.H_PIX(H_PIX), .V_LINES(V_LINES), .XW(XW), .YW(YW)) u_cnt (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clear   (clr_s),
      .advance (adv_s),
      .x_cnt   (x_cnt_s),
      .y_cnt   (y_cnt_s),
      .sof     (sof_s),
      .sol     (sol_s),
      .last    (last_s)
   );

`ifdef OV_TEST_PATTERN_EN
   logic [2:0] bar_idx_s;
   assign bar_idx_s = 3'((32'(x_cnt_s) * 32'd8) / 32'(H_PIX));
   assign src_pix_s = tp_r ? bar_colour(bar_idx_s) : {OV_DATA, OV_DATA};
   assign tp_nxt_s  = ((state_r == ST_IDLE) && START) ? TP_EN : tp_r;
`else
   assign src_pix_s = {OV_DATA, OV_DATA};
   assign tp_nxt_s  = 1'b0;
`endif

   // Next-state and next-output logic; rclk_r doubles as the fetch phase (1 = first half of a byte)
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rclk_nxt_s  = rclk_r;
      rrst_nxt_s  = rrst_r;
      oe_nxt_s    = oe_r;
      data_nxt_s  = data_r;
      valid_nxt_s = valid_r;
      sof_nxt_s   = sof_r;
      sol_nxt_s   = sol_r;
      busy_nxt_s  = busy_r;
      done_nxt_s  = 1'b0;
      clr_s       = 1'b0;
      adv_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            rclk_nxt_s = 1'b0;
            oe_nxt_s   = 1'b1;
            if (START) begin
               state_nxt_s = ST_RRST;
               busy_nxt_s  = 1'b1;
               oe_nxt_s    = 1'b0;
               rrst_nxt_s  = 1'b0;
               cnt_nxt_s   = '0;
               clr_s       = 1'b1;
            end else begin
               busy_nxt_s = 1'b0;
            end
         end
         ST_RRST: begin
            clr_s = 1'b1;
            // Release the pointer reset in its own cycle with the read clock low
            if (cnt_r == CNT_RELEASE) begin
               state_nxt_s = ST_FETCH_HI;
               rclk_nxt_s  = 1'b1;
            end else if (cnt_r == CNT_LAST_RISE) begin
               cnt_nxt_s  = CNT_RELEASE;
               rclk_nxt_s = 1'b0;
               rrst_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s  = cnt_r + CW'(1);
               rclk_nxt_s = ~rclk_r;
            end
         end
         ST_FETCH_HI: begin
            if (rclk_r) begin
               rclk_nxt_s = 1'b0;
            end else begin
               data_nxt_s[15:8] = src_pix_s[15:8];
               rclk_nxt_s       = 1'b1;
               state_nxt_s      = ST_FETCH_LO;
            end
         end
         ST_FETCH_LO: begin
            if (rclk_r) begin
               rclk_nxt_s = 1'b0;
            end else begin
               data_nxt_s[7:0] = src_pix_s[7:0];
               state_nxt_s     = ST_PUSH;
               valid_nxt_s     = 1'b1;
               sof_nxt_s       = sof_s;
               sol_nxt_s       = sol_s;
            end
         end
         ST_PUSH: begin
            if (PIX_READY) begin
               valid_nxt_s = 1'b0;
               adv_s       = 1'b1;
               if (last_s) begin
                  state_nxt_s = ST_FIN;
                  done_nxt_s  = 1'b1;
                  busy_nxt_s  = 1'b0;
                  oe_nxt_s    = 1'b1;
               end else begin
                  state_nxt_s = ST_FETCH_HI;
                  rclk_nxt_s  = 1'b1;
               end
            end else begin
               rclk_nxt_s = 1'b0;
            end
         end
         ST_FIN: begin
            clr_s       = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            rclk_nxt_s  = 1'b0;
            rrst_nxt_s  = 1'b1;
            oe_nxt_s    = 1'b1;
            valid_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
            clr_s       = 1'b1;
         end
      endcase
   end

   // State and registered outputs; pattern mode parks the FIFO pins but keeps the timing
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         rclk_r    <= 1'b0;
         rrst_r    <= 1'b1;
         oe_r      <= 1'b1;
         ov_rclk_r <= 1'b0;
         ov_rrst_r <= 1'b1;
         ov_oe_r   <= 1'b1;
         data_r    <= 16'h0000;
         valid_r   <= 1'b0;
         sof_r     <= 1'b0;
         sol_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         tp_r      <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         rclk_r    <= rclk_nxt_s;
         rrst_r    <= rrst_nxt_s;
         oe_r      <= oe_nxt_s;
         ov_rclk_r <= rclk_nxt_s & ~tp_nxt_s;
         ov_rrst_r <= rrst_nxt_s | tp_nxt_s;
         ov_oe_r   <= oe_nxt_s | tp_nxt_s;
         data_r    <= data_nxt_s;
         valid_r   <= valid_nxt_s;
         sof_r     <= sof_nxt_s;
         sol_r     <= sol_nxt_s;
         busy_r    <= busy_nxt_s;
         done_r    <= done_nxt_s;
         tp_r      <= tp_nxt_s;
      end
   end

   assign OV_RCLK   = ov_rclk_r;
   assign OV_RRST   = ov_rrst_r;
   assign OV_OE     = ov_oe_r;
   assign PIX_DATA  = data_r;
   assign PIX_VALID = valid_r;
   assign PIX_SOF   = sof_r;
   assign PIX_SOL   = sol_r;
   assign BUSY      = busy_r;
   assign DONE      = done_r;

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Directed bench for ov_fifo_reader with a behavioural AL422 read port (byte n = n[7:0] after pointer reset).
module tb_ov_fifo_reader;

`ifdef OV_TEST_PATTERN_EN
   localparam int H = 8;
`else
   localparam int H = 4;
`endif
   localparam int V    = 2;
   localparam int NPIX = H * V;
   localparam int RC   = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic        PIX_READY = 1'b0;
   logic        TP_EN = 1'b0;
   logic [7:0]  OV_DATA;
   logic        OV_RCLK, OV_RRST, OV_OE;
   logic [15:0] PIX_DATA;
   logic        PIX_VALID, PIX_SOF, PIX_SOL, BUSY, DONE;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   ov_fifo_reader #(.H_PIX(H), .V_LINES(V), .RRST_CYC(RC)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
`ifdef OV_TEST_PATTERN_EN
      .TP_EN     (TP_EN),
`endif
      .OV_DATA   (OV_DATA),
      .OV_RCLK   (OV_RCLK),
      .OV_RRST   (OV_RRST),
      .OV_OE     (OV_OE),
      .PIX_DATA  (PIX_DATA),
      .PIX_VALID (PIX_VALID),
      .PIX_READY (PIX_READY),
      .PIX_SOF   (PIX_SOF),
      .PIX_SOL   (PIX_SOL),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   // AL422 read port: pointer reset sampled on RCLK rise, otherwise emit next byte
   logic [15:0] rd_ptr = 16'd0;
   logic [7:0]  fifo_q = 8'd0;
   int rclk_edges = 0;
   int rrst_edges = 0;
   int rrst_bad   = 0;
   int done_cnt   = 0;
   logic [15:0] pix_q[$];
   bit          sof_q[$];
   bit          sol_q[$];

   always @(posedge OV_RCLK) begin
      rclk_edges++;
      if (!OV_RRST) begin
         rrst_edges++;
         rd_ptr <= 16'd0;
      end else begin
         fifo_q <= rd_ptr[7:0];
         rd_ptr <= rd_ptr + 16'd1;
      end
   end
   assign OV_DATA = OV_OE ? 8'hEE : fifo_q;

   always @(posedge OV_RRST) if (OV_RCLK === 1'b1) rrst_bad++;

   always @(negedge CLK) begin
      if (PIX_VALID && PIX_READY) begin
         pix_q.push_back(PIX_DATA);
         sof_q.push_back(PIX_SOF);
         sol_q.push_back(PIX_SOL);
      end
      if (DONE) done_cnt++;
   end

   function automatic logic [15:0] exp_pix(input int k);
      return {8'(2 * k), 8'(2 * k + 1)};
   endfunction

   task automatic pulse_start();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input int bd, input int budget);
      for (int i = 0; i < budget && done_cnt == bd; i++) @(negedge CLK);
      checks++;
      if (done_cnt == bd) begin
         errors++;
         $display("FAIL wait_done: no DONE within %0d cycles", budget);
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic wait_pix(input int n, input int budget);
      for (int i = 0; i < budget && pix_q.size() < n; i++) @(negedge CLK);
      checks++;
      if (pix_q.size() < n) begin
         errors++;
         $display("FAIL wait_pix: got %0d pixels, need %0d", pix_q.size(), n);
      end
   endtask

   task automatic test_reset();
      logic [23:0] obs;
      repeat (3) @(negedge CLK);
      obs = {OV_RCLK, OV_RRST, OV_OE, PIX_VALID, PIX_SOF, PIX_SOL, BUSY, DONE, PIX_DATA};
      checks++;
      if (obs !== {8'b0110_0000, 16'h0000}) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", obs, {8'b0110_0000, 16'h0000});
      end
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      obs = {OV_RCLK, OV_RRST, OV_OE, PIX_VALID, PIX_SOF, PIX_SOL, BUSY, DONE, PIX_DATA};
      checks++;
      if (obs !== {8'b0110_0000, 16'h0000}) begin
         errors++;
         $display("FAIL idle_after_reset: got %h expected %h", obs, {8'b0110_0000, 16'h0000});
      end
   endtask

   task automatic test_basic_frame();
      int base = pix_q.size();
      int bd   = done_cnt;
      int be   = rclk_edges;
      PIX_READY = 1'b1;
      pulse_start();
      checks++;
      if (BUSY !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b expected 1", BUSY);
      end
      wait_done(bd, 2000);
      checks++;
      if (pix_q.size() - base != NPIX) begin
         errors++;
         $display("FAIL basic_count: got %0d expected %0d", pix_q.size() - base, NPIX);
      end
      for (int k = 0; k < NPIX; k++) begin
         checks++;
         if (pix_q[base + k] !== exp_pix(k) || sof_q[base + k] !== (k == 0) || sol_q[base + k] !== (k % H == 0)) begin
            errors++;
            $display("FAIL basic_pix%0d: got %h sof=%b sol=%b expected %h sof=%b sol=%b", k,
                     pix_q[base + k], sof_q[base + k], sol_q[base + k], exp_pix(k), (k == 0), (k % H == 0));
         end
      end
      checks++;
      if (done_cnt - bd != 1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got done=%0d busy=%b expected 1 and 0", done_cnt - bd, BUSY);
      end
      checks++;
      if (rclk_edges - be != RC + 2 * NPIX) begin
         errors++;
         $display("FAIL basic_rclk_edges: got %0d expected %0d", rclk_edges - be, RC + 2 * NPIX);
      end
   endtask

   task automatic test_pointer_reset();
      int base = pix_q.size();
      int bd   = done_cnt;
      int br   = rrst_edges;
      int bb   = rrst_bad;
      PIX_READY = 1'b1;
      pulse_start();
      wait_done(bd, 2000);
      checks++;
      if (rrst_edges - br != RC) begin
         errors++;
         $display("FAIL rrst_periods: got %0d expected %0d", rrst_edges - br, RC);
      end
      checks++;
      if (rrst_bad != bb) begin
         errors++;
         $display("FAIL rrst_release_rclk_low: got %0d bad releases expected 0", rrst_bad - bb);
      end
      checks++;
      if (pix_q[base] !== 16'h0001) begin
         errors++;
         $display("FAIL second_frame_first: got %h expected 0001", pix_q[base]);
      end
   endtask

   task automatic test_backpressure();
      int base = pix_q.size();
      int bd   = done_cnt;
      int be;
      int bad = 0;
      PIX_READY = 1'b1;
      pulse_start();
      wait_pix(base + 2, 500);
      @(posedge CLK);
      #1 PIX_READY = 1'b0;
      for (int i = 0; i < 50 && PIX_VALID !== 1'b1; i++) @(negedge CLK);
      @(negedge CLK);
      be = rclk_edges;
      repeat (20) begin
         @(negedge CLK);
         if (PIX_DATA !== 16'h0405 || OV_RCLK !== 1'b0 || PIX_VALID !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0 || rclk_edges != be) begin
         errors++;
         $display("FAIL stall_hold: got %0d unstable cycles, %0d rclk edges, expected 0 and 0", bad, rclk_edges - be);
      end
      checks++;
      if (PIX_DATA !== 16'h0405) begin
         errors++;
         $display("FAIL stall_data: got %h expected 0405", PIX_DATA);
      end
      PIX_READY = 1'b1;
      wait_done(bd, 2000);
      checks++;
      if (pix_q[base + 2] !== 16'h0405 || pix_q[base + 3] !== 16'h0607) begin
         errors++;
         $display("FAIL after_stall: got %h %h expected 0405 0607", pix_q[base + 2], pix_q[base + 3]);
      end
      checks++;
      if (pix_q.size() - base != NPIX) begin
         errors++;
         $display("FAIL stall_count: got %0d expected %0d", pix_q.size() - base, NPIX);
      end
   endtask

   task automatic test_reset_mid_frame();
      int base = pix_q.size();
      int bd   = done_cnt;
      logic [23:0] obs;
      PIX_READY = 1'b1;
      pulse_start();
      wait_pix(base + 4, 500);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1 obs = {OV_RCLK, OV_RRST, OV_OE, PIX_VALID, PIX_SOF, PIX_SOL, BUSY, DONE, PIX_DATA};
      checks++;
      if (obs !== {8'b0110_0000, 16'h0000}) begin
         errors++;
         $display("FAIL mid_reset_values: got %h expected %h", obs, {8'b0110_0000, 16'h0000});
      end
      repeat (4) @(negedge CLK);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      checks++;
      if (done_cnt != bd || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_no_done: got done=%0d busy=%b expected 0 and 0", done_cnt - bd, BUSY);
      end
      base = pix_q.size();
      pulse_start();
      wait_done(bd, 2000);
      checks++;
      if (pix_q[base] !== 16'h0001 || pix_q.size() - base != NPIX) begin
         errors++;
         $display("FAIL restart_after_reset: got %h count %0d expected 0001 count %0d", pix_q[base], pix_q.size() - base, NPIX);
      end
   endtask

   task automatic test_start_while_busy();
      int base = pix_q.size();
      int bd   = done_cnt;
      PIX_READY = 1'b1;
      pulse_start();
      wait_pix(base + 5, 500);
      pulse_start();
      wait_done(bd, 2000);
      repeat (30) @(negedge CLK);
      checks++;
      if (pix_q.size() - base != NPIX || done_cnt - bd != 1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL start_busy_ignored: got pixels=%0d done=%0d busy=%b expected %0d 1 0",
                  pix_q.size() - base, done_cnt - bd, BUSY, NPIX);
      end
      checks++;
      if (pix_q[base + NPIX - 1] !== exp_pix(NPIX - 1)) begin
         errors++;
         $display("FAIL start_busy_last: got %h expected %h", pix_q[base + NPIX - 1], exp_pix(NPIX - 1));
      end
   endtask

`ifdef OV_TEST_PATTERN_EN
   task automatic test_pattern();
      logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      int base = pix_q.size();
      int bd   = done_cnt;
      int be   = rclk_edges;
      TP_EN = 1'b1;
      PIX_READY = 1'b1;
      pulse_start();
      TP_EN = 1'b0;
      wait_done(bd, 2000);
      checks++;
      if (rclk_edges != be) begin
         errors++;
         $display("FAIL tp_rclk_static: got %0d edges expected 0", rclk_edges - be);
      end
      for (int k = 0; k < NPIX; k++) begin
         checks++;
         if (pix_q[base + k] !== bars[k % H]) begin
            errors++;
            $display("FAIL tp_pix%0d: got %h expected %h", k, pix_q[base + k], bars[k % H]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_pointer_reset();
      test_backpressure();
      test_reset_mid_frame();
      test_start_while_busy();
`ifdef OV_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
